// File: rtl/agc_ctrl.sv
// ============================================================================
// Module   : agc_ctrl
// Brief    : Scale/offset load sequencer and gain-apply controller for a bank of
//            agc_dsp slices. It also gathers windowed gt/lt saturation statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module agc_ctrl #(
    parameter int NCHAN       = 8,
    parameter int CHAN_BITS   = 3,
    parameter int OFFSET_BITS = 16,
    parameter int WIN_LOG2    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_i,
    input  logic                   wr_sel_i,
    input  logic [CHAN_BITS-1:0]   wr_chan_i,
    input  logic [16:0]            wr_data_i,
    output logic                   wr_ready_o,
    output logic                   wr_err_o,
    input  logic                   apply_req_i,
    input  logic                   sync_i,
    output logic [16:0]            scale_o,
    output logic [OFFSET_BITS-1:0] offset_o,
    output logic [NCHAN-1:0]       ce_scale_o,
    output logic [NCHAN-1:0]       ce_offset_o,
    output logic                   apply_o,
    output logic                   apply_pending_o,
    input  logic [NCHAN-1:0]       gt_i,
    input  logic [NCHAN-1:0]       lt_i,
    input  logic [CHAN_BITS-1:0]   stat_chan_i,
    output logic [WIN_LOG2:0]      gt_count_o,
    output logic [WIN_LOG2:0]      lt_count_o,
    output logic                   stat_valid_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_APPLY = 2'd3;

    localparam logic [NCHAN-1:0]     ONE_HOT0 = {{(NCHAN-1){1'b0}}, 1'b1};
    localparam logic [WIN_LOG2:0]    CNT_FULL = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [CHAN_BITS:0]   NCHAN_W  = (CHAN_BITS+1)'(NCHAN);

    logic [1:0]             state_q, state_d;
    logic                   pending_q, pending_d;
    logic                   rdy_q;
    logic                   wr_accept;
    logic                   chan_ok;
    logic [NCHAN-1:0]       ce_hit;
    logic [16:0]            scale_q;
    logic [OFFSET_BITS-1:0] offset_q;
    logic [NCHAN-1:0]       ce_scale_q, ce_offset_q;
    logic                   wr_err_q;

    // rdy_q keeps ready low during reset and until the first clock after release.
    assign wr_ready_o      = rdy_q & (state_q == S_IDLE) & ~pending_q;
    assign wr_accept       = wr_i & wr_ready_o;
    assign chan_ok         = {1'b0, wr_chan_i} < NCHAN_W;
    assign ce_hit          = chan_ok ? (ONE_HOT0 << wr_chan_i) : '0;
    assign apply_o         = (state_q == S_APPLY);
    assign apply_pending_o = pending_q;
    assign scale_o         = scale_q;
    assign offset_o        = offset_q;
    assign ce_scale_o      = ce_scale_q;
    assign ce_offset_o     = ce_offset_q;
    assign wr_err_o        = wr_err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr_accept)      state_d = S_LOAD;
                else if (pending_q) state_d = S_WAIT;
            end
            S_LOAD:  state_d = (pending_q | apply_req_i) ? S_WAIT : S_IDLE;
            S_WAIT:  if (sync_i) state_d = S_APPLY;
            S_APPLY: state_d = apply_req_i ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A request arriving on the sync cycle is merged into the apply it triggers.
    always_comb begin
        if (state_q == S_WAIT && sync_i) pending_d = 1'b0;
        else if (state_q == S_APPLY)     pending_d = apply_req_i;
        else                             pending_d = pending_q | apply_req_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            rdy_q       <= 1'b0;
            scale_q     <= '0;
            offset_q    <= '0;
            ce_scale_q  <= '0;
            ce_offset_q <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rdy_q       <= 1'b1;
            if (wr_accept && !wr_sel_i) scale_q  <= wr_data_i;
            if (wr_accept && wr_sel_i)  offset_q <= wr_data_i[OFFSET_BITS-1:0];
            ce_scale_q  <= (wr_accept && !wr_sel_i) ? ce_hit : '0;
            ce_offset_q <= (wr_accept && wr_sel_i)  ? ce_hit : '0;
            wr_err_q    <= wr_accept & ~chan_ok;
        end
    end

    logic [NCHAN-1:0]     gt_r_q, lt_r_q;
    logic [CHAN_BITS-1:0] sel_q, sel_cur;
    logic [WIN_LOG2-1:0]  win_q;
    logic [WIN_LOG2:0]    gt_cnt_q, lt_cnt_q, gt_sum, lt_sum;
    logic [WIN_LOG2:0]    gt_out_q, lt_out_q;
    logic                 valid_q;
    logic                 gt_bit, lt_bit;

    // The monitored channel is taken live on the first window cycle, then held.
    assign sel_cur = (win_q == '0) ? stat_chan_i : sel_q;

    always_comb begin
        gt_bit = 1'b0;
        lt_bit = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (sel_cur == CHAN_BITS'(i)) begin
                gt_bit = gt_r_q[i];
                lt_bit = lt_r_q[i];
            end
        end
    end

    assign gt_sum = gt_cnt_q + {{WIN_LOG2{1'b0}}, (gt_bit && gt_cnt_q != CNT_FULL)};
    assign lt_sum = lt_cnt_q + {{WIN_LOG2{1'b0}}, (lt_bit && lt_cnt_q != CNT_FULL)};

    assign gt_count_o   = gt_out_q;
    assign lt_count_o   = lt_out_q;
    assign stat_valid_o = valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gt_r_q   <= '0;
            lt_r_q   <= '0;
            sel_q    <= '0;
            win_q    <= '0;
            gt_cnt_q <= '0;
            lt_cnt_q <= '0;
            gt_out_q <= '0;
            lt_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            gt_r_q  <= gt_i;
            lt_r_q  <= lt_i;
            sel_q   <= sel_cur;
            valid_q <= 1'b0;
            if (apply_o) begin
                // Statistics gathered at the old gain are discarded.
                win_q    <= '0;
                gt_cnt_q <= '0;
                lt_cnt_q <= '0;
            end else if (&win_q) begin
                gt_out_q <= gt_sum;
                lt_out_q <= lt_sum;
                valid_q  <= 1'b1;
                win_q    <= '0;
                gt_cnt_q <= '0;
                lt_cnt_q <= '0;
            end else begin
                win_q    <= win_q + 1'b1;
                gt_cnt_q <= gt_sum;
                lt_cnt_q <= lt_sum;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_agc_ctrl.sv
// ============================================================================
// Module   : tb_agc_ctrl
// Brief    : Directed self-checking bench for agc_ctrl with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_agc_ctrl;

    localparam int NCHAN = 8;
    localparam int CB    = 4;
    localparam int OB    = 16;
    localparam int WL    = 4;
    localparam int WIN   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr = 1'b0, wr_sel = 1'b0;
    logic [CB-1:0] wr_chan = '0;
    logic [16:0]   wr_data = '0;
    logic          apply_req = 1'b0, sync = 1'b0;
    logic [7:0]    gt = '0, lt = '0;
    logic [CB-1:0] stat_chan = '0;

    logic          wr_ready, wr_err, apply, apply_pending, stat_valid;
    logic [16:0]   scale;
    logic [OB-1:0] offset;
    logic [7:0]    ce_scale, ce_offset;
    logic [WL:0]   gt_count, lt_count;

    agc_ctrl #(.NCHAN(NCHAN), .CHAN_BITS(CB), .OFFSET_BITS(OB), .WIN_LOG2(WL)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_i(wr), .wr_sel_i(wr_sel), .wr_chan_i(wr_chan), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready), .wr_err_o(wr_err),
        .apply_req_i(apply_req), .sync_i(sync),
        .scale_o(scale), .offset_o(offset),
        .ce_scale_o(ce_scale), .ce_offset_o(ce_offset),
        .apply_o(apply), .apply_pending_o(apply_pending),
        .gt_i(gt), .lt_i(lt), .stat_chan_i(stat_chan),
        .gt_count_o(gt_count), .lt_count_o(lt_count), .stat_valid_o(stat_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_apply = 0;

    // Behavioural model: what each output must show during the current cycle.
    bit          m_clocked, m_pend, m_load, m_wait, m_fire, m_err, m_valid;
    logic [16:0] m_scale;
    logic [15:0] m_off;
    logic [7:0]  m_ce_s, m_ce_o, m_pg, m_pl;
    logic [4:0]  m_gout, m_lout;
    int          m_len, m_gsum, m_lsum, m_sel;

    function automatic bit m_ready();
        return m_clocked && !m_pend && !m_load && !m_wait && !m_fire;
    endfunction

    task automatic model_reset();
        m_clocked = 0; m_pend = 0; m_load = 0; m_wait = 0; m_fire = 0;
        m_err = 0; m_valid = 0; m_scale = '0; m_off = '0; m_ce_s = '0; m_ce_o = '0;
        m_pg = '0; m_pl = '0; m_gout = '0; m_lout = '0;
        m_len = 0; m_gsum = 0; m_lsum = 0; m_sel = 0;
    endtask

    task automatic model_clock();
        bit acc, idle, n_fire, n_wait, n_pend;
        int gb, lb;
        if (!rst_n) begin
            model_reset();
            return;
        end
        idle   = !m_load && !m_wait && !m_fire;
        acc    = m_ready() && wr;
        n_fire = m_wait && sync;
        n_wait = (m_wait && !sync) || (m_load && (m_pend || apply_req))
                 || (idle && m_pend) || (m_fire && apply_req);
        n_pend = n_fire ? 1'b0 : (m_fire ? apply_req : (m_pend || apply_req));
        m_ce_s = (acc && !wr_sel && wr_chan < NCHAN) ? (8'd1 << wr_chan) : 8'd0;
        m_ce_o = (acc && wr_sel && wr_chan < NCHAN) ? (8'd1 << wr_chan) : 8'd0;
        m_err  = acc && (wr_chan >= NCHAN);
        if (acc && !wr_sel) m_scale = wr_data;
        if (acc && wr_sel)  m_off = wr_data[15:0];
        // Statistics: accumulate one delayed sample per clock, full window = WIN samples.
        m_valid = 0;
        if (m_fire) begin
            m_len = 0; m_gsum = 0; m_lsum = 0;
        end else begin
            if (m_len == 0) m_sel = int'(stat_chan);
            gb = (m_sel < NCHAN) ? int'(m_pg[m_sel]) : 0;
            lb = (m_sel < NCHAN) ? int'(m_pl[m_sel]) : 0;
            m_gsum += gb;
            m_lsum += lb;
            m_len++;
            if (m_len == WIN) begin
                m_gout  = 5'((m_gsum > WIN) ? WIN : m_gsum);
                m_lout  = 5'((m_lsum > WIN) ? WIN : m_lsum);
                m_valid = 1;
                m_len = 0; m_gsum = 0; m_lsum = 0;
            end
        end
        m_pg = gt; m_pl = lt;
        m_load = acc; m_wait = n_wait; m_fire = n_fire; m_pend = n_pend;
        m_clocked = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("wr_ready",      32'(wr_ready),      32'(m_ready()));
        chk("wr_err",        32'(wr_err),        32'(m_err));
        chk("scale",         32'(scale),         32'(m_scale));
        chk("offset",        32'(offset),        32'(m_off));
        chk("ce_scale",      32'(ce_scale),      32'(m_ce_s));
        chk("ce_offset",     32'(ce_offset),     32'(m_ce_o));
        chk("apply",         32'(apply),         32'(m_fire));
        chk("apply_pending", 32'(apply_pending), 32'(m_pend));
        chk("stat_valid",    32'(stat_valid),    32'(m_valid));
        chk("gt_count",      32'(gt_count),      32'(m_gout));
        chk("lt_count",      32'(lt_count),      32'(m_lout));
        chk("ce_apply_overlap", 32'((|ce_scale || |ce_offset) && apply), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        if (apply) n_apply++;
        compare_all();
    endtask

    task automatic drive_stats();
        gt = (8'($urandom) & 8'hFB) | 8'h04;
        lt = 8'($urandom) & 8'hFB;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        model_reset();
        #2;
        compare_all();
        chk("reset_ready_lit", 32'(wr_ready), 32'd0);
        step(); step();
        #2 rst_n = 1'b1;
        step();
        chk("ready_after_release_lit", 32'(wr_ready), 32'd1);

        // Scale write to channel 3
        wr = 1; wr_sel = 0; wr_chan = 4'd3; wr_data = 17'h01000;
        step();
        wr = 0;
        chk("t1_scale_lit", 32'(scale), 32'h01000);
        chk("t1_ce_lit",    32'(ce_scale), 32'h08);
        chk("t1_ready_lit", 32'(wr_ready), 32'd0);
        step();
        chk("t1_ce_clear_lit", 32'(ce_scale), 32'd0);

        // Offset write, request, sync ten cycles later
        wr = 1; wr_sel = 1; wr_chan = 4'd0; wr_data = 17'h0FF80;
        step();
        wr = 0;
        chk("t2_offset_lit", 32'(offset), 32'hFF80);
        step();
        n_apply = 0;
        apply_req = 1;
        step();
        apply_req = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("t2_ready_low_lit", 32'(wr_ready), 32'd0);
        end
        sync = 1;
        step();
        sync = 0;
        chk("t2_apply_lit", 32'(apply), 32'd1);
        step();
        chk("t2_apply_once_lit", 32'(n_apply), 32'd1);
        chk("t2_ready_back_lit", 32'(wr_ready), 32'd1);

        // Write and request together with sync held high
        wr = 1; wr_sel = 1; wr_chan = 4'd5; wr_data = 17'h00123; apply_req = 1; sync = 1;
        step();
        wr = 0; apply_req = 0;
        chk("t3_ce5_lit", 32'(ce_offset), 32'h20);
        chk("t3_no_apply_lit", 32'(apply), 32'd0);
        step();
        chk("t3_no_apply_yet_lit", 32'(apply), 32'd0);
        step();
        chk("t3_apply_lit", 32'(apply), 32'd1);
        sync = 0;
        step();

        // Statistics on channel 2, other channels toggling
        stat_chan = 4'd2;
        for (int i = 0; i < 40; i++) begin
            drive_stats();
            step();
        end
        stat_chan = 4'd1;
        for (int i = 0; i < 5; i++) begin
            drive_stats();
            step();
        end
        stat_chan = 4'd2;
        for (int i = 0; i < 20; i++) begin
            drive_stats();
            step();
        end

        // Abort a window with an apply
        for (int i = 0; i < 7; i++) begin
            drive_stats();
            step();
        end
        apply_req = 1; sync = 1;
        k = 0;
        do begin
            drive_stats();
            step();
            apply_req = 0;
            k++;
        end while (!apply && k < 6);
        sync = 0;
        chk("t5_apply_seen_lit", 32'(apply), 32'd1);
        k = 0;
        do begin
            drive_stats();
            step();
            k++;
        end while (!stat_valid && k < 40);
        chk("t5_valid_latency_lit", 32'(k), 32'd17);
        chk("t5_gt_full_lit", 32'(gt_count), 32'd16);
        chk("t5_lt_zero_lit", 32'(lt_count), 32'd0);

        // Out-of-range statistics channel yields zero counts
        stat_chan = 4'd9;
        gt = 8'hFF; lt = 8'hFF;
        k = 0;
        do begin
            step();
            k++;
        end while (!stat_valid && k < 40);
        chk("t5b_valid_seen_lit", 32'(stat_valid), 32'd1);
        for (int i = 0; i < 20; i++) step();
        chk("t5b_gt_zero_lit", 32'(gt_count), 32'd0);
        chk("t5b_lt_zero_lit", 32'(lt_count), 32'd0);

        // Out-of-range write, then reset while waiting for sync
        wr = 1; wr_sel = 0; wr_chan = 4'd9; wr_data = 17'h1ABCD;
        step();
        wr = 0;
        chk("t6_err_lit", 32'(wr_err), 32'd1);
        chk("t6_no_ce_lit", 32'(ce_scale | ce_offset), 32'd0);
        step();
        chk("t6_err_pulse_lit", 32'(wr_err), 32'd0);
        apply_req = 1;
        step();
        apply_req = 0;
        step(); step();
        chk("t6_pending_lit", 32'(apply_pending), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("t6_rst_pending_lit", 32'(apply_pending), 32'd0);
        chk("t6_rst_ready_lit", 32'(wr_ready), 32'd0);
        chk("t6_rst_scale_lit", 32'(scale), 32'd0);
        step(); step();
        #2 rst_n = 1'b1;
        n_apply = 0;
        sync = 1;
        for (int i = 0; i < 10; i++) step();
        sync = 0;
        chk("t6_no_apply_lit", 32'(n_apply), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
